// File: rtl/dino_motion_if.sv
// Bus between the input/collision logic and the dino motion controller.
// Ports (signals):
//   frame_tick, jump, duck, hit, restart, ground_y  - driven by the master
//   dino_y, dino_h, sprite_sel, airborne, dead        - driven by the controller (slave)
interface dino_motion_if #(
   parameter int YW = 11
);
   logic          frame_tick;
   logic          jump;
   logic          duck;
   logic          hit;
   logic          restart;
   logic [YW-1:0] ground_y;
   logic [YW-1:0] dino_y;
   logic [YW-1:0] dino_h;
   logic [2:0]    sprite_sel;
   logic          airborne;
   logic          dead;

   modport master (
      output frame_tick, jump, duck, hit, restart, ground_y,
      input  dino_y, dino_h, sprite_sel, airborne, dead
   );

   modport slave (
      input  frame_tick, jump, duck, hit, restart, ground_y,
      output dino_y, dino_h, sprite_sel, airborne, dead
   );
endinterface

// File: rtl/dino_motion_ctrl.sv
// T-Rex jump/duck/death controller, one physics step per video frame.
// Keeps altitude above the ground line and a signed vertical velocity,
// with variable-height jump, fast-fall and a two-phase run animation.
// Ports:
//   clk  - system clock
//   rst  - synchronous reset, active-high
//   bus  - dino_motion_if slave: frame_tick/jump/duck/hit/restart/ground_y in,
//          dino_y/dino_h/sprite_sel/airborne/dead out (all registered)
module dino_motion_ctrl #(
   parameter int YW          = 11,
   parameter int VW          = 8,
   parameter int JUMP_V      = 10,
   parameter int GRAVITY     = 1,
   parameter int HOLD_FRAMES = 4,
   parameter int FASTFALL_G  = 3,
   parameter int MAX_FALL    = 12,
   parameter int ANIM_DIV    = 6,
   parameter int STAND_H     = 47,
   parameter int DUCK_H      = 30
) (
   input logic         clk,
   input logic         rst,
   dino_motion_if.slave bus
);
   localparam int HW = (HOLD_FRAMES < 2) ? 1 : $clog2(HOLD_FRAMES + 1);
   localparam int AW = (ANIM_DIV < 2) ? 1 : $clog2(ANIM_DIV);

   localparam logic [HW-1:0]        HOLD_MAX = HW'(HOLD_FRAMES);
   localparam logic signed [VW+1:0] G_NORM   = (VW+2)'(GRAVITY);
   localparam logic signed [VW+1:0] G_FAST   = (VW+2)'(FASTFALL_G);
   localparam logic signed [VW+1:0] V_FLOOR  = (VW+2)'(-MAX_FALL);
   localparam logic signed [VW-1:0] V_LAUNCH = VW'(JUMP_V);

   typedef enum logic [2:0] {S_IDLE, S_RUN, S_DUCK, S_AIR, S_DEAD} state_t;

   state_t                state, state_nx;
   logic [YW-1:0]         alt, alt_nx;
   logic signed [VW-1:0]  vel, vel_nx;
   logic [HW-1:0]         hold_cnt, hold_nx;
   logic [AW-1:0]         anim, anim_nx;
   logic                  phase, phase_nx;

   logic signed [YW:0]    s_sum;
   logic signed [VW+1:0]  vel_wide;
   logic signed [VW+1:0]  g_eff;

   // Downward speed is limited to the terminal velocity.
   function automatic logic signed [VW-1:0] fall_clamp(input logic signed [VW+1:0] v);
      logic signed [VW+1:0] r;
      r = (v < V_FLOOR) ? V_FLOOR : v;
      return r[VW-1:0];
   endfunction

   function automatic logic [2:0] sel_of(input state_t st, input logic ph);
      case (st)
         S_RUN:   return ph ? 3'd2 : 3'd1;
         S_DUCK:  return ph ? 3'd5 : 3'd4;
         S_AIR:   return 3'd3;
         S_DEAD:  return 3'd6;
         default: return 3'd0;
      endcase
   endfunction

   always_comb begin
      state_nx = state;
      alt_nx   = alt;
      vel_nx   = vel;
      hold_nx  = hold_cnt;
      anim_nx  = anim;
      phase_nx = phase;

      vel_wide = {{2{vel[VW-1]}}, vel};
      s_sum    = $signed({1'b0, alt}) + $signed({{(YW+1-VW){vel[VW-1]}}, vel});

      // The launch frame counts as the first held frame, so a held jump
      // gets HOLD_FRAMES-1 gravity-free air steps.
      if (bus.duck)
         g_eff = G_FAST;
      else if (bus.jump && (vel > 0) && (int'(hold_cnt) + 1 < HOLD_FRAMES))
         g_eff = '0;
      else
         g_eff = G_NORM;

      if (state == S_DEAD) begin
         if (bus.restart) begin
            state_nx = S_IDLE;
            alt_nx   = '0;
            vel_nx   = '0;
            hold_nx  = '0;
            anim_nx  = '0;
            phase_nx = 1'b0;
         end
      end else if (bus.hit && (state != S_IDLE)) begin
         state_nx = S_DEAD;
      end else if (bus.frame_tick) begin
         if ((state == S_RUN) || (state == S_DUCK)) begin
            if (int'(anim) == ANIM_DIV - 1) begin
               anim_nx  = '0;
               phase_nx = ~phase;
            end else begin
               anim_nx = anim + AW'(1);
            end
         end

         if (state == S_AIR) begin
            if (s_sum <= 0) begin
               // Landing tick never relaunches, even with jump held.
               alt_nx   = '0;
               vel_nx   = '0;
               state_nx = bus.duck ? S_DUCK : S_RUN;
            end else begin
               if (s_sum > $signed({1'b0, bus.ground_y})) begin
                  alt_nx = bus.ground_y;
                  vel_nx = '0;
               end else begin
                  alt_nx = s_sum[YW-1:0];
                  vel_nx = fall_clamp(vel_wide - g_eff);
               end
               // Releasing jump ends the hold window for the rest of this jump.
               if (!bus.jump)
                  hold_nx = HOLD_MAX;
               else if (hold_cnt < HOLD_MAX)
                  hold_nx = hold_cnt + HW'(1);
            end
         end else if (bus.jump) begin
            state_nx = S_AIR;
            alt_nx   = '0;
            vel_nx   = V_LAUNCH;
            hold_nx  = '0;
         end else if ((state == S_RUN) && bus.duck) begin
            state_nx = S_DUCK;
         end else if ((state == S_DUCK) && !bus.duck) begin
            state_nx = S_RUN;
         end
      end
   end

   // State update and output register: outputs follow state one edge later.
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= S_IDLE;
         alt            <= '0;
         vel            <= '0;
         hold_cnt       <= '0;
         anim           <= '0;
         phase          <= 1'b0;
         bus.dino_y     <= bus.ground_y;
         bus.dino_h     <= YW'(STAND_H);
         bus.sprite_sel <= 3'd0;
         bus.airborne   <= 1'b0;
         bus.dead       <= 1'b0;
      end else begin
         state          <= state_nx;
         alt            <= alt_nx;
         vel            <= vel_nx;
         hold_cnt       <= hold_nx;
         anim           <= anim_nx;
         phase          <= phase_nx;
         bus.dino_y     <= bus.ground_y - alt;
         bus.dino_h     <= (state == S_DUCK) ? YW'(DUCK_H) : YW'(STAND_H);
         bus.sprite_sel <= sel_of(state, phase);
         bus.airborne   <= (alt != '0);
         bus.dead       <= (state == S_DEAD);
      end
   end
endmodule

// File: tb/tb_dino_motion_ctrl.sv
// Testbench for dino_motion_ctrl: directed jump/duck/death scenarios followed by
// randomized input traffic, all compared against a frame-level behavioural model.
module tb_dino_motion_ctrl;
   localparam int HOLD_FRAMES = 4;
   localparam int ANIM_DIV    = 6;
   localparam int M_IDLE = 0, M_RUN = 1, M_DUCK = 2, M_AIR = 3, M_DEAD = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;

   dino_motion_if #(.YW(11)) bus ();

   dino_motion_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial forever #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // behavioural model
   int gy;
   int m_st, m_alt, m_vel, m_hold_left, m_anim, m_phase;
   int e_y, e_h, e_sel, e_air, e_dead;

   int obs [0:63];
   int land_k, peak;
   int sel0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      tests++;
      assert (got === want) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, want);
      end
   endtask

   function automatic int sel_model(input int st, input int ph);
      case (st)
         M_RUN:   return 1 + ph;
         M_DUCK:  return 4 + ph;
         M_AIR:   return 3;
         M_DEAD:  return 6;
         default: return 0;
      endcase
   endfunction

   task automatic model_reset();
      m_st = M_IDLE; m_alt = 0; m_vel = 0; m_hold_left = 0; m_anim = 0; m_phase = 0;
      e_y = gy; e_h = 47; e_sel = 0; e_air = 0; e_dead = 0;
   endtask

   // One clock edge of the model; outputs show the state held before the edge.
   task automatic model_edge(input bit t, input bit j, input bit d, input bit h, input bit r);
      int s, g;
      e_y    = gy - m_alt;
      e_h    = (m_st == M_DUCK) ? 30 : 47;
      e_sel  = sel_model(m_st, m_phase);
      e_air  = (m_alt != 0) ? 1 : 0;
      e_dead = (m_st == M_DEAD) ? 1 : 0;
      if (m_st == M_DEAD) begin
         if (r) begin
            m_st = M_IDLE; m_alt = 0; m_vel = 0; m_hold_left = 0; m_anim = 0; m_phase = 0;
         end
      end else if (h && m_st != M_IDLE) begin
         m_st = M_DEAD;
      end else if (t) begin
         if (m_st == M_RUN || m_st == M_DUCK) begin
            m_anim++;
            if (m_anim == ANIM_DIV) begin
               m_anim = 0;
               m_phase = 1 - m_phase;
            end
         end
         if (m_st != M_AIR) begin
            if (j) begin
               m_st = M_AIR; m_alt = 0; m_vel = 10; m_hold_left = HOLD_FRAMES - 1;
            end else if (m_st == M_RUN && d) m_st = M_DUCK;
            else if (m_st == M_DUCK && !d) m_st = M_RUN;
         end else begin
            s = m_alt + m_vel;
            if (s <= 0) begin
               m_alt = 0; m_vel = 0;
               m_st = d ? M_DUCK : M_RUN;
            end else begin
               if (!j) m_hold_left = 0;
               if (d) g = 3;
               else if (j && m_vel > 0 && m_hold_left > 0) g = 0;
               else g = 1;
               if (m_hold_left > 0) m_hold_left--;
               if (s > gy) begin
                  m_alt = gy; m_vel = 0;
               end else begin
                  m_alt = s;
                  m_vel = (m_vel - g < -12) ? -12 : m_vel - g;
               end
            end
         end
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".dino_y"},     32'(bus.dino_y),     e_y);
      chk({tag, ".dino_h"},     32'(bus.dino_h),     e_h);
      chk({tag, ".sprite_sel"}, 32'(bus.sprite_sel), e_sel);
      chk({tag, ".airborne"},   32'(bus.airborne),   e_air);
      chk({tag, ".dead"},       32'(bus.dead),       e_dead);
   endtask

   task automatic step(input bit t, input bit j, input bit d, input bit h, input bit r);
      bus.frame_tick = t; bus.jump = j; bus.duck = d; bus.hit = h; bus.restart = r;
      @(posedge clk);
      model_edge(t, j, d, h, r);
      @(negedge clk);
      check_all("cycle");
   endtask

   // A tick cycle followed by a quiet cycle, so outputs show the post-tick state.
   task automatic frame(input bit j, input bit d);
      step(1'b1, j, d, 1'b0, 1'b0);
      step(1'b0, j, d, 1'b0, 1'b0);
   endtask

   task automatic do_reset(input int g);
      gy = g;
      bus.ground_y = 11'(g);
      bus.frame_tick = 1'b0; bus.jump = 1'b0; bus.duck = 1'b0; bus.hit = 1'b0; bus.restart = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      check_all("reset");
   endtask

   // Launch, then fly until the sprite leaves JUMP; obs[k] = altitude after air tick k.
   task automatic jump_run(input int hold_ticks, input int duck_from, input bit launch_duck);
      frame(1'b1, launch_duck);
      sel0 = int'(bus.sprite_sel);
      obs[0] = gy - int'(bus.dino_y);
      land_k = -1;
      peak = 0;
      for (int k = 1; k <= 60 && land_k < 0; k++) begin
         frame(k <= hold_ticks, k >= duck_from);
         obs[k] = gy - int'(bus.dino_y);
         if (obs[k] > peak) peak = obs[k];
         if (bus.sprite_sel != 3'd3) land_k = k;
      end
      chk("landing_within_bound", 32'(land_k >= 0), 32'd1);
   endtask

   initial begin
      bus.frame_tick = 1'b0; bus.jump = 1'b0; bus.duck = 1'b0; bus.hit = 1'b0; bus.restart = 1'b0;
      bus.ground_y = 11'd200;
      gy = 200;

      do_reset(200);
      chk("reset_y", 32'(bus.dino_y), 32'd200);
      chk("reset_sel", 32'(bus.sprite_sel), 32'd0);
      chk("reset_dead", 32'(bus.dead), 32'd0);

      // Tapped jump: alt 10,19,27,... peak 55 on ticks 10-11, lands tick 21.
      jump_run(0, 1000, 1'b0);
      chk("tap_alt1", obs[1], 10);
      chk("tap_alt2", obs[2], 19);
      chk("tap_alt3", obs[3], 27);
      chk("tap_alt10", obs[10], 55);
      chk("tap_alt11", obs[11], 55);
      chk("tap_peak", peak, 55);
      chk("tap_land_tick", land_k, 21);
      chk("tap_land_sel", 32'(bus.sprite_sel), 32'd1);

      // Run animation: 6 ticks per phase.
      for (int k = 1; k <= 12; k++) begin
         frame(1'b0, 1'b0);
         chk("run_anim_sel", 32'(bus.sprite_sel), ((k / 6) % 2 == 1) ? 32'd2 : 32'd1);
      end

      // jump + duck on the same tick launches.
      jump_run(0, 1000, 1'b1);
      chk("jump_duck_sel", sel0, 3);

      // Held jump: 10,20,30,40,49..., peak 85.
      jump_run(12, 1000, 1'b0);
      chk("held_alt1", obs[1], 10);
      chk("held_alt3", obs[3], 30);
      chk("held_alt4", obs[4], 40);
      chk("held_alt5", obs[5], 49);
      chk("held_peak", peak, 85);

      // Released after first air tick: 10,20,29..., peak 65.
      jump_run(1, 1000, 1'b0);
      chk("rel_alt2", obs[2], 20);
      chk("rel_alt3", obs[3], 29);
      chk("rel_peak", peak, 65);

      // Duck at the peak: vel -3,-6,-9,-12,-12, land into DUCK.
      jump_run(0, 11, 1'b0);
      chk("ff_alt11", obs[11], 55);
      chk("ff_alt12", obs[12], 52);
      chk("ff_alt13", obs[13], 46);
      chk("ff_alt14", obs[14], 37);
      chk("ff_alt15", obs[15], 25);
      chk("ff_alt16", obs[16], 13);
      chk("ff_land_tick", land_k, 18);
      chk("ff_land_h", 32'(bus.dino_h), 32'd30);

      // Death on a non-tick cycle at alt 40, then restart.
      frame(1'b0, 1'b0);
      frame(1'b1, 1'b0);
      for (int k = 1; k <= 4; k++) frame(1'b1, 1'b0);
      chk("pre_hit_y", 32'(bus.dino_y), 32'd160);
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("dead_flag", 32'(bus.dead), 32'd1);
      chk("dead_sel", 32'(bus.sprite_sel), 32'd6);
      chk("dead_y", 32'(bus.dino_y), 32'd160);
      for (int k = 0; k < 3; k++) frame(1'b1, 1'b1);
      chk("dead_frozen_y", 32'(bus.dino_y), 32'd160);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("restart_sel", 32'(bus.sprite_sel), 32'd0);
      chk("restart_y", 32'(bus.dino_y), 32'd200);

      // Reset mid-jump at alt 30.
      frame(1'b1, 1'b0);
      for (int k = 1; k <= 3; k++) frame(1'b1, 1'b0);
      chk("midjump_y", 32'(bus.dino_y), 32'd170);
      do_reset(200);
      chk("midjump_reset_y", 32'(bus.dino_y), 32'd200);
      chk("midjump_reset_sel", 32'(bus.sprite_sel), 32'd0);

      // Low ground line: held jump is clamped at the ceiling.
      do_reset(60);
      jump_run(12, 1000, 1'b0);
      chk("ceiling_peak", peak, 60);

      // Randomized traffic.
      for (int i = 0; i < 800; i++) begin
         step($urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
              $urandom_range(0, 59) == 0, $urandom_range(0, 7) == 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
